// File: rtl/csr_counter_bank_if.sv
// csr_counter_bank_if: CSR access request/response bundle between the execute stage and the counter bank.
interface csr_counter_bank_if;
    logic        req_valid;
    logic [11:0] csr_num;
    logic        read_csr;
    logic        write_csr;
    logic [2:0]  write_function;
    logic [31:0] write_value;
    logic        resp_valid;
    logic [31:0] read_value;
    logic        illegal_instr_exception;

    modport master (
        output req_valid, csr_num, read_csr, write_csr, write_function, write_value,
        input  resp_valid, read_value, illegal_instr_exception
    );
    modport slave (
        input  req_valid, csr_num, read_csr, write_csr, write_function, write_value,
        output resp_valid, read_value, illegal_instr_exception
    );
endinterface

// File: rtl/csr_counter_bank.sv
// csr_counter_bank: RV32 cycle/time/instret/hpm counter CSRs with mcountinhibit and mhpmevent.
// One request per cycle; the registered response carries the pre-modification value.
module csr_counter_bank #(
    parameter int COUNTER_WIDTH = 64,
    parameter int NUM_HPM       = 4,
    parameter int NUM_EVENTS    = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  instr_retired,
    input  logic                  time_tick,
    input  logic [NUM_EVENTS-1:0] event_in,
    csr_counter_bank_if.slave     bus
);
    localparam int CW = COUNTER_WIDTH;
    localparam int NC = 3 + NUM_HPM;
    localparam int NH = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam int EW = $clog2(NUM_EVENTS + 1);
    localparam logic [5:0]    NC_L     = 6'(NC);
    localparam logic [EW-1:0] EV_MAX   = EW'(NUM_EVENTS);
    localparam logic [31:0]   INH_MASK = 32'(64'h5 | (((64'h1 << NUM_HPM) - 64'h1) << 3));

    logic [CW-1:0] cnt_q [NC];
    logic [CW-1:0] cnt_d [NC];
    logic [31:0]   inh_q, inh_d;
    logic [EW-1:0] evt_q [NH];
    logic [EW-1:0] evt_d [NH];
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   read_value_q, read_value_d;
    logic          illegal_q, illegal_d;

    logic [4:0]          idx;
    logic                hi, is_user, cnt_ok, inh_ok, evt_ok, illegal, we;
    logic [63:0]         sel;
    logic [31:0]         old32, new32;
    logic [NC-1:0]       inc;
    logic [NUM_EVENTS:0] ev_sh;
    logic                unused_ok;

    assign unused_ok = bus.write_function[2];

    always_comb begin
        idx     = bus.csr_num[4:0];
        hi      = bus.csr_num[7];
        is_user = bus.csr_num[11:8] == 4'hC;
        // time has no machine-mode alias, so B01/B81 stay unimplemented
        cnt_ok  = (is_user || bus.csr_num[11:8] == 4'hB) && bus.csr_num[6:5] == 2'b00 &&
                  {1'b0, idx} < NC_L && !(!is_user && idx == 5'd1);
        inh_ok  = bus.csr_num == 12'h320;
        evt_ok  = bus.csr_num[11:5] == 7'h19 && idx >= 5'd3 && {1'b0, idx} < NC_L;
        illegal = !(bus.read_csr || bus.write_csr) || !(cnt_ok || inh_ok || evt_ok) ||
                  (bus.write_csr && (is_user || bus.write_function[1:0] == 2'b00));
        we      = bus.req_valid && bus.write_csr && !illegal;
        sel     = inh_ok ? 64'(inh_q) : '0;
        for (int i = 0; i < NC; i++)
            if (cnt_ok && idx == 5'(i)) sel = 64'(cnt_q[i]);
        for (int k = 0; k < NUM_HPM; k++)
            if (evt_ok && idx == 5'(k + 3)) sel = 64'(evt_q[k]);
        old32 = (cnt_ok && hi) ? sel[63:32] : sel[31:0];
        new32 = bus.write_function[1:0] == 2'b01 ? bus.write_value :
                bus.write_function[1:0] == 2'b10 ? old32 | bus.write_value :
                                                   old32 & ~bus.write_value;
        ev_sh  = {event_in, 1'b0};
        inc    = '0;
        inc[0] = !inh_q[0];
        inc[1] = time_tick;
        inc[2] = instr_retired && !inh_q[2];
        for (int k = 0; k < NUM_HPM; k++)
            inc[k + 3] = ev_sh[evt_q[k]] && !inh_q[k + 3];
        // a write replaces the increment of the whole counter, not just the written half
        for (int i = 0; i < NC; i++) begin
            cnt_d[i] = cnt_q[i] + {{(CW - 1){1'b0}}, inc[i]};
            if (we && cnt_ok && idx == 5'(i))
                cnt_d[i] = hi ? {new32[CW-33:0], cnt_q[i][31:0]} : {cnt_q[i][CW-1:32], new32};
        end
        inh_d = (we && inh_ok) ? new32 & INH_MASK : inh_q;
        evt_d = evt_q;
        for (int k = 0; k < NUM_HPM; k++)
            if (we && evt_ok && idx == 5'(k + 3))
                evt_d[k] = (new32[EW-1:0] > EV_MAX) ? '0 : new32[EW-1:0];
        resp_valid_d = bus.req_valid;
        illegal_d    = bus.req_valid && illegal;
        read_value_d = (bus.req_valid && !illegal) ? old32 : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '{default: '0};
            inh_q        <= '0;
            evt_q        <= '{default: '0};
            resp_valid_q <= 1'b0;
            read_value_q <= '0;
            illegal_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            inh_q        <= inh_d;
            evt_q        <= evt_d;
            resp_valid_q <= resp_valid_d;
            read_value_q <= read_value_d;
            illegal_q    <= illegal_d;
        end
    end

    assign bus.resp_valid              = resp_valid_q;
    assign bus.read_value              = read_value_q;
    assign bus.illegal_instr_exception = illegal_q;
endmodule

// File: tb/tb_csr_counter_bank.sv
// tb_csr_counter_bank: directed and randomized checks of csr_counter_bank against a table-driven model.
module tb_csr_counter_bank;
    localparam int CW = 64;
    localparam int NH = 4;
    localparam int NE = 8;
    localparam int NC = 3 + NH;
    localparam logic [31:0] INH_WRITABLE = 32'h7D;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          instr_retired = 1'b0;
    logic          time_tick = 1'b0;
    logic [NE-1:0] event_in = '0;

    csr_counter_bank_if bus();

    csr_counter_bank #(.COUNTER_WIDTH(CW), .NUM_HPM(NH), .NUM_EVENTS(NE)) dut (
        .clock(clock), .reset_n(reset_n), .instr_retired(instr_retired),
        .time_tick(time_tick), .event_in(event_in), .bus(bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    longint unsigned m_cnt [NC];
    logic [31:0]     m_inh;
    int              m_evt [NH];
    int              kind_of [int];
    int              idx_of [int];
    bit              hi_of [int];
    logic            exp_rv, exp_ill;
    logic [31:0]     exp_rd;

    // kind: 1 user counter (read-only), 2 machine counter, 3 mcountinhibit, 4 mhpmevent
    task automatic build_map();
        for (int i = 0; i < NC; i++) begin
            kind_of['hC00 + i] = 1; idx_of['hC00 + i] = i; hi_of['hC00 + i] = 0;
            kind_of['hC80 + i] = 1; idx_of['hC80 + i] = i; hi_of['hC80 + i] = 1;
            if (i != 1) begin
                kind_of['hB00 + i] = 2; idx_of['hB00 + i] = i; hi_of['hB00 + i] = 0;
                kind_of['hB80 + i] = 2; idx_of['hB80 + i] = i; hi_of['hB80 + i] = 1;
            end
        end
        kind_of['h320] = 3; idx_of['h320] = 0; hi_of['h320] = 0;
        for (int k = 0; k < NH; k++) begin
            kind_of['h323 + k] = 4; idx_of['h323 + k] = k; hi_of['h323 + k] = 0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) m_cnt[i] = 0;
        for (int k = 0; k < NH; k++) m_evt[k] = 0;
        m_inh = '0;
    endtask

    task automatic model_step(input logic req, input int a, input logic rd, input logic wr,
                              input logic [2:0] wf, input logic [31:0] wv, input logic ir,
                              input logic tick, input logic [NE-1:0] ev);
        longint unsigned nxt [NC];
        longint unsigned full;
        logic [31:0] old, nw;
        int kd, ix, ev_sel;
        bit h, legal;
        kd = 0; ix = 0; h = 0; old = '0;
        if (kind_of.exists(a)) begin
            kd = kind_of[a]; ix = idx_of[a]; h = hi_of[a];
        end
        legal = req && kd != 0 && (rd || wr) && !(wr && (kd == 1 || wf[1:0] == 2'b00));
        if (kd == 1 || kd == 2) begin
            full = m_cnt[ix];
            old = h ? full[63:32] : full[31:0];
        end else if (kd == 3) old = m_inh;
        else if (kd == 4) old = 32'(m_evt[ix]);
        nw = (wf[1:0] == 2'b01) ? wv : (wf[1:0] == 2'b10) ? (old | wv) : (old & ~wv);
        nxt[0] = m_cnt[0] + (m_inh[0] ? 64'd0 : 64'd1);
        nxt[1] = m_cnt[1] + (tick ? 64'd1 : 64'd0);
        nxt[2] = m_cnt[2] + ((ir && !m_inh[2]) ? 64'd1 : 64'd0);
        for (int k = 0; k < NH; k++) begin
            ev_sel = m_evt[k];
            nxt[3 + k] = m_cnt[3 + k] + ((ev_sel != 0 && ev[ev_sel - 1] && !m_inh[3 + k]) ? 64'd1 : 64'd0);
        end
        if (legal && wr) begin
            if (kd == 2) begin
                full = m_cnt[ix];
                if (h) full[63:32] = nw; else full[31:0] = nw;
                nxt[ix] = full;
            end else if (kd == 3) m_inh = nw & INH_WRITABLE;
            else if (kd == 4) m_evt[ix] = (int'(nw % 16) > NE) ? 0 : int'(nw % 16);
        end
        for (int i = 0; i < NC; i++) m_cnt[i] = nxt[i];
        exp_rv  = req;
        exp_ill = req && !legal;
        exp_rd  = legal ? old : 32'd0;
    endtask

    task automatic cyc(input logic req, input logic [11:0] addr, input logic rd, input logic wr,
                       input logic [2:0] wf, input logic [31:0] wv, input logic ir,
                       input logic tick, input logic [NE-1:0] ev);
        bus.req_valid = req; bus.csr_num = addr; bus.read_csr = rd; bus.write_csr = wr;
        bus.write_function = wf; bus.write_value = wv;
        instr_retired = ir; time_tick = tick; event_in = ev;
        @(posedge clock);
        model_step(req, int'(addr), rd, wr, wf, wv, ir, tick, ev);
        #1;
    endtask

    task automatic acc(input logic [11:0] addr, input logic rd, input logic wr,
                       input logic [2:0] wf, input logic [31:0] wv);
        cyc(1'b1, addr, rd, wr, wf, wv, 1'b0, 1'b0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 12'h0, 1'b0, 1'b0, 3'b0, 32'h0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_reset();
        bus.req_valid = 0; bus.csr_num = 0; bus.read_csr = 0; bus.write_csr = 0;
        bus.write_function = 0; bus.write_value = 0;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.resp_valid, bus.read_value, bus.illegal_instr_exception} !== 34'd0) begin
            failures++;
            $display("FAIL reset_outputs: got rv=%0b rd=%h ill=%0b want all zero",
                     bus.resp_valid, bus.read_value, bus.illegal_instr_exception);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_cycle_start();
        idle(10);
        acc(12'hC00, 1, 0, 3'b000, 0);
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.read_value !== 32'd10 || bus.illegal_instr_exception !== 1'b0) begin
            failures++;
            $display("FAIL cycle_after_10: got rv=%0b rd=%0d ill=%0b want rv=1 rd=10 ill=0",
                     bus.resp_valid, bus.read_value, bus.illegal_instr_exception);
        end
        acc(12'hC80, 1, 0, 3'b000, 0);
        checks++;
        if (bus.read_value !== 32'd0) begin
            failures++;
            $display("FAIL cycleh_zero: got %h want 0", bus.read_value);
        end
    endtask

    task automatic test_wrap();
        acc(12'hB00, 0, 1, 3'b001, 32'hFFFF_FFFF);
        acc(12'hB80, 0, 1, 3'b001, 32'hFFFF_FFFF);
        acc(12'hC00, 1, 0, 3'b000, 0);
        checks++;
        if (bus.read_value !== 32'hFFFF_FFFF || exp_rd !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL wrap_all_ones: got %h model %h want ffffffff", bus.read_value, exp_rd);
        end
        acc(12'hC00, 1, 0, 3'b000, 0);
        checks++;
        if (bus.read_value !== 32'd0) begin
            failures++;
            $display("FAIL wrap_to_zero: got %h want 0", bus.read_value);
        end
        acc(12'hC80, 1, 0, 3'b000, 0);
        checks++;
        if (bus.read_value !== 32'd0) begin
            failures++;
            $display("FAIL wrap_high_zero: got %h want 0", bus.read_value);
        end
    endtask

    task automatic test_illegal();
        logic [11:0] bad [6];
        logic [2:0]  bad_rw [6];
        bad = '{12'hC02, 12'h7FF, 12'hC07, 12'hB01, 12'hB02, 12'h320};
        bad_rw = '{3'b011, 3'b010, 3'b010, 3'b010, 3'b100, 3'b000};
        for (int i = 0; i < 6; i++) begin
            acc(bad[i], bad_rw[i][1], bad_rw[i][0], (bad_rw[i] == 3'b100) ? 3'b000 : 3'b001, 32'h5);
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.illegal_instr_exception !== 1'b1 || bus.read_value !== 32'd0) begin
                failures++;
                $display("FAIL illegal_%03h: got rv=%0b ill=%0b rd=%h want rv=1 ill=1 rd=0",
                         bad[i], bus.resp_valid, bus.illegal_instr_exception, bus.read_value);
            end
        end
        acc(12'hB02, 1, 0, 3'b000, 0);
        checks++;
        if (bus.illegal_instr_exception !== 1'b0 || bus.read_value !== 32'd0) begin
            failures++;
            $display("FAIL instret_untouched: got ill=%0b rd=%h want ill=0 rd=0",
                     bus.illegal_instr_exception, bus.read_value);
        end
    endtask

    task automatic test_hpm_event();
        acc(12'h323, 0, 1, 3'b001, 32'd2);
        for (int i = 0; i < 3; i++) cyc(0, 12'h0, 0, 0, 3'b0, 0, 0, 0, 8'b10);
        cyc(0, 12'h0, 0, 0, 3'b0, 0, 0, 0, 8'b01);
        acc(12'hC03, 1, 0, 3'b000, 0);
        checks++;
        if (bus.read_value !== 32'd3 || exp_rd !== 32'd3) begin
            failures++;
            $display("FAIL hpm3_count: got %0d model %0d want 3", bus.read_value, exp_rd);
        end
        acc(12'h323, 0, 1, 3'b001, NE + 1);
        acc(12'h323, 1, 0, 3'b000, 0);
        checks++;
        if (bus.read_value !== 32'd0 || bus.illegal_instr_exception !== 1'b0) begin
            failures++;
            $display("FAIL event_out_of_range: got rd=%0d ill=%0b want rd=0 ill=0",
                     bus.read_value, bus.illegal_instr_exception);
        end
    endtask

    task automatic test_inhibit();
        logic [31:0] frozen;
        acc(12'h320, 0, 1, 3'b010, 32'h1);
        acc(12'hC00, 1, 0, 3'b000, 0);
        frozen = exp_rd;
        idle(5);
        acc(12'hC00, 1, 0, 3'b000, 0);
        checks++;
        if (bus.read_value !== frozen) begin
            failures++;
            $display("FAIL cycle_inhibited: got %h want %h", bus.read_value, frozen);
        end
        acc(12'h320, 0, 1, 3'b011, 32'h1);
        idle(1);
        acc(12'hC00, 1, 0, 3'b000, 0);
        checks++;
        if (bus.read_value !== frozen + 32'd1) begin
            failures++;
            $display("FAIL cycle_resumed: got %h want %h", bus.read_value, frozen + 32'd1);
        end
        acc(12'h320, 0, 1, 3'b001, 32'hFFFF_FFFF);
        acc(12'h320, 1, 0, 3'b000, 0);
        checks++;
        if (bus.read_value !== INH_WRITABLE) begin
            failures++;
            $display("FAIL inhibit_fields: got %h want %h", bus.read_value, INH_WRITABLE);
        end
        acc(12'h320, 0, 1, 3'b001, 32'h0);
    endtask

    task automatic test_back_to_back();
        acc(12'hB82, 0, 1, 3'b001, 32'h1234_5678);
        acc(12'hC82, 1, 0, 3'b000, 0);
        checks++;
        if (bus.read_value !== 32'h1234_5678) begin
            failures++;
            $display("FAIL b2b_write_read: got %h want 12345678", bus.read_value);
        end
        acc(12'hB82, 1, 1, 3'b010, 32'h1);
        checks++;
        if (bus.read_value !== 32'h1234_5678) begin
            failures++;
            $display("FAIL b2b_set_old: got %h want 12345678", bus.read_value);
        end
        acc(12'hC82, 1, 0, 3'b000, 0);
        checks++;
        if (bus.read_value !== 32'h1234_5679) begin
            failures++;
            $display("FAIL b2b_set_new: got %h want 12345679", bus.read_value);
        end
    endtask

    task automatic test_random();
        int pool [$];
        int a;
        logic [31:0] wv;
        for (int i = 0; i < NC; i++) pool.push_back('hC00 + i);
        for (int i = 0; i < NC; i++) pool.push_back('hC80 + i);
        for (int i = 0; i < NC; i++) pool.push_back('hB00 + i);
        for (int i = 0; i < NC; i++) pool.push_back('hB80 + i);
        for (int k = 0; k < NH; k++) pool.push_back('h323 + k);
        pool.push_back('h320); pool.push_back('h321); pool.push_back('h327);
        pool.push_back('h7FF); pool.push_back('hC07); pool.push_back('h000);
        for (int n = 0; n < 400; n++) begin
            a = pool[$urandom_range(0, pool.size() - 1)];
            wv = (a >= 'h323 && a <= 'h326) ? 32'($urandom_range(0, 15)) : $urandom;
            cyc($urandom_range(0, 4) != 0, 12'(a), 1'($urandom), 1'($urandom), 3'($urandom),
                wv, 1'($urandom), 1'($urandom), NE'($urandom));
            checks++;
            if ({bus.resp_valid, bus.read_value, bus.illegal_instr_exception} !== {exp_rv, exp_rd, exp_ill}) begin
                failures++;
                $display("FAIL random_%0d addr=%03h: got rv=%0b rd=%h ill=%0b want rv=%0b rd=%h ill=%0b",
                         n, a, bus.resp_valid, bus.read_value, bus.illegal_instr_exception,
                         exp_rv, exp_rd, exp_ill);
            end
        end
    endtask

    task automatic test_reset_midop();
        acc(12'hC00, 1, 0, 3'b000, 0);
        bus.req_valid = 1; bus.csr_num = 12'hB02; bus.read_csr = 1; bus.write_csr = 1;
        bus.write_function = 3'b001; bus.write_value = 32'hDEAD_BEEF; instr_retired = 1;
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.resp_valid, bus.read_value, bus.illegal_instr_exception} !== 34'd0) begin
            failures++;
            $display("FAIL midop_reset_outputs: got rv=%0b rd=%h ill=%0b want all zero",
                     bus.resp_valid, bus.read_value, bus.illegal_instr_exception);
        end
        @(negedge clock);
        bus.req_valid = 0; bus.read_csr = 0; bus.write_csr = 0; instr_retired = 0;
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        acc(12'hB02, 1, 0, 3'b000, 0);
        checks++;
        if (bus.read_value !== 32'd0 || bus.illegal_instr_exception !== 1'b0) begin
            failures++;
            $display("FAIL midop_minstret: got rd=%h ill=%0b want rd=0 ill=0",
                     bus.read_value, bus.illegal_instr_exception);
        end
        acc(12'hC00, 1, 0, 3'b000, 0);
        checks++;
        if (bus.read_value !== 32'd1) begin
            failures++;
            $display("FAIL midop_first_increment: got %0d want 1", bus.read_value);
        end
    endtask

    initial begin
        build_map();
        model_reset();
        test_reset();
        test_cycle_start();
        test_wrap();
        test_illegal();
        test_hpm_event();
        test_inhibit();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
